dmem_responder: RTL and testbench

Data-memory responder that services the word load/store requests the retire stage drives on its dmem_* outputs. Contains a word-addressed RAM and a fixed-latency read pipeline. Each load is tagged with its ROB address, and results return on a tagged load-result port that feeds reservation-station forwarding. In-flight loads are squashed when a mispredicted branch is signalled.

---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder_rd_pipe.sv | 65 ++++++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   rob_addr_t        - reorder-buffer tag carried by loads
//   dmem_ld_result_t  - {valid, rob_addr, data} entry of the read pipeline
//   sat_add           - 32-bit saturating add used by the optional counters
package dmem_responder_pkg;

  localparam int unsigned ROB_ADDR_WIDTH = 5;
  typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;

  localparam int unsigned DMEM_DEPTH_WORDS_DEF = 1024;
  localparam int unsigned DMEM_IDX_WIDTH       = $clog2(DMEM_DEPTH_WORDS_DEF);

  typedef struct packed {
    logic        valid;
    rob_addr_t   rob_addr;
    logic [31:0] data;
  } dmem_ld_result_t;

  function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/result bus between the retire stage (master) and the data-memory
// responder (slave).
//   requests : dmem_wr_en_in, dmem_rd_en_in, dmem_addr_in, dmem_data_in,
//              dmem_rob_addr_in, flush_in
//   results  : ld_valid_out, ld_rob_addr_out, ld_data_out, req_err_out
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        dmem_wr_en_in;
  logic        dmem_rd_en_in;
  logic [31:0] dmem_addr_in;
  logic [31:0] dmem_data_in;
  rob_addr_t   dmem_rob_addr_in;
  logic        flush_in;

  logic        ld_valid_out;
  rob_addr_t   ld_rob_addr_out;
  logic [31:0] ld_data_out;
  logic        req_err_out;

  modport master (
    output dmem_wr_en_in, dmem_rd_en_in, dmem_addr_in, dmem_data_in, dmem_rob_addr_in, flush_in,
    input  ld_valid_out, ld_rob_addr_out, ld_data_out, req_err_out
  );

  modport slave (
    input  dmem_wr_en_in, dmem_rd_en_in, dmem_addr_in, dmem_data_in, dmem_rob_addr_in, flush_in,
    output ld_valid_out, ld_rob_addr_out, ld_data_out, req_err_out
  );

endinterface

// File: rtl/dmem_responder_rd_pipe.sv
// Fixed-latency load pipeline: RD_LATENCY stages of {valid, rob_addr, data}.
// Stage 0 captures the request (RAM data already read at the request edge);
// the last stage is the registered load-result output.
//   clk, rst    - clock, asynchronous active-low reset
//   flush       - clears every valid bit and drops the incoming request
//   req         - incoming load entry
//   res         - final stage (load result)
//   flushed_cnt - valid entries not yet presented, discarded by a flush now
//                 (only with QU_DMEM_STATS_EN)
module dmem_responder_rd_pipe
  import dmem_responder_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  dmem_ld_result_t req,
  output dmem_ld_result_t res
`ifdef QU_DMEM_STATS_EN
  ,
  output logic [2:0]      flushed_cnt
`endif
);

  dmem_ld_result_t stage_q [RD_LATENCY];
  dmem_ld_result_t stage_in [RD_LATENCY];

  always_comb begin
    stage_in[0] = req;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_in[i] = stage_q[i-1];
    end
  end

  // Tag/data only move with a live entry so the output holds its last result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i].valid <= stage_in[i].valid & ~flush;
        if (stage_in[i].valid && !flush) begin
          stage_q[i].rob_addr <= stage_in[i].rob_addr;
          stage_q[i].data     <= stage_in[i].data;
        end
      end
    end
  end

  assign res = stage_q[RD_LATENCY-1];

`ifdef QU_DMEM_STATS_EN
  // The final stage has already been presented, so it is not counted.
  always_comb begin
    flushed_cnt = '0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      flushed_cnt = flushed_cnt + {2'b00, stage_q[i].valid};
    end
  end
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, request decode/reject logic and a tagged
// fixed-latency load pipeline. Optional statistics counters are compiled in
// with the QU_DMEM_STATS_EN macro.
//   clk, rst - clock, asynchronous active-low reset
//   bus      - dmem_responder_if.slave request/result bus
//   stat_*   - accepted loads, performed stores, rejected requests, flushed
//              pipeline entries (saturating, QU_DMEM_STATS_EN only)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH_WORDS = DMEM_DEPTH_WORDS_DEF,
  parameter int unsigned RD_LATENCY       = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_responder_if.slave bus
`ifdef QU_DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads_out,
  output logic [31:0] stat_stores_out,
  output logic [31:0] stat_errs_out,
  output logic [31:0] stat_flushed_out
`endif
);

  localparam int unsigned IdxW = $clog2(DMEM_DEPTH_WORDS);

  logic [31:0]     mem [DMEM_DEPTH_WORDS];
  logic [IdxW-1:0] idx;
  logic            misaligned;
  logic            wr_ok;
  logic            rd_ok;
  logic            err_d;
  logic            err_q;
  dmem_ld_result_t rd_req;
  dmem_ld_result_t rd_res;

  // Upper address bits are ignored so addresses wrap modulo the depth.
  assign idx = bus.dmem_addr_in[IdxW+1:2];
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.dmem_addr_in[31:IdxW+2];

  // A store wins over a simultaneous load; the load is dropped and flagged.
  always_comb begin
    misaligned = (bus.dmem_wr_en_in || bus.dmem_rd_en_in) && (bus.dmem_addr_in[1:0] != 2'b00);
    wr_ok      = bus.dmem_wr_en_in && !misaligned;
    rd_ok      = bus.dmem_rd_en_in && !bus.dmem_wr_en_in && !misaligned && !bus.flush_in;
    err_d      = misaligned || (bus.dmem_wr_en_in && bus.dmem_rd_en_in);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[idx] <= bus.dmem_data_in;
    end
  end

  // RAM is read at the request edge; a store from an earlier edge is already
  // in the array, so there is no stale-read window.
  always_comb begin
    rd_req.valid    = rd_ok;
    rd_req.rob_addr = bus.dmem_rob_addr_in;
    rd_req.data     = mem[idx];
  end

`ifdef QU_DMEM_STATS_EN
  logic [2:0] flushed_cnt;
`endif

  dmem_responder_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .flush       (bus.flush_in),
    .req         (rd_req),
    .res         (rd_res)
`ifdef QU_DMEM_STATS_EN
    ,
    .flushed_cnt (flushed_cnt)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.ld_valid_out    = rd_res.valid;
  assign bus.ld_rob_addr_out = rd_res.rob_addr;
  assign bus.ld_data_out     = rd_res.data;
  assign bus.req_err_out     = err_q;

`ifdef QU_DMEM_STATS_EN
  logic [31:0] loads_q, stores_q, errs_q, flushed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loads_q   <= '0;
      stores_q  <= '0;
      errs_q    <= '0;
      flushed_q <= '0;
    end else begin
      loads_q   <= sat_add(loads_q, {31'd0, rd_ok});
      stores_q  <= sat_add(stores_q, {31'd0, wr_ok});
      errs_q    <= sat_add(errs_q, {31'd0, err_d});
      flushed_q <= sat_add(flushed_q, bus.flush_in ? {29'd0, flushed_cnt} : 32'd0);
    end
  end

  assign stat_loads_out   = loads_q;
  assign stat_stores_out  = stores_q;
  assign stat_errs_out    = errs_q;
  assign stat_flushed_out = flushed_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard of expected load
// results and reject pulses, checked every cycle on the falling edge.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    int          due;
    rob_addr_t   rob;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

`ifdef QU_DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs, stat_flushed;
`endif

  dmem_responder #(
    .DMEM_DEPTH_WORDS (DEPTH),
    .RD_LATENCY       (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus)
`ifdef QU_DMEM_STATS_EN
    ,
    .stat_loads_out   (stat_loads),
    .stat_stores_out  (stat_stores),
    .stat_errs_out    (stat_errs),
    .stat_flushed_out (stat_flushed)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        ld_q[$];
  int          err_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_data = '0;
  rob_addr_t   last_rob = '0;
  logic        mon_en = 1'b0;
  int          m_loads = 0, m_stores = 0, m_errs = 0, m_flushed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a result is due in the cycle following edge 'due'.
  always @(negedge clk) begin
    logic exp_v;
    logic exp_e;
    if (mon_en && rst) begin
      while (ld_q.size() > 0 && ld_q[0].due < cyc) void'(ld_q.pop_front());
      while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
      exp_v = (ld_q.size() > 0) && (ld_q[0].due == cyc);
      if (exp_v) begin
        last_data = ld_q[0].data;
        last_rob  = ld_q[0].rob;
        void'(ld_q.pop_front());
      end
      exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
      if (exp_e) void'(err_q.pop_front());
      chk("ld_valid", 64'(bus.ld_valid_out), 64'(exp_v));
      chk("ld_rob", 64'(bus.ld_rob_addr_out), 64'(last_rob));
      chk("ld_data", 64'(bus.ld_data_out), 64'(last_data));
      chk("req_err", 64'(bus.req_err_out), 64'(exp_e));
    end
  end

  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, input rob_addr_t rob, input logic fl);
    int   e;
    int   idx;
    logic mis;
    exp_t keep[$];
    @(negedge clk);
    bus.dmem_wr_en_in    = wr;
    bus.dmem_rd_en_in    = rd;
    bus.dmem_addr_in     = addr;
    bus.dmem_data_in     = data;
    bus.dmem_rob_addr_in = rob;
    bus.flush_in         = fl;
    e   = cyc + 1;
    idx = int'((addr >> 2) % DEPTH);
    mis = (wr || rd) && (addr[1:0] != 2'b00);
    if (mis || (wr && rd)) begin
      err_q.push_back(e);
      m_errs++;
    end
    if (wr && !mis) begin
      mem_m[idx] = data;
      m_stores++;
    end
    if (fl) begin
      foreach (ld_q[i]) begin
        if (ld_q[i].due < e) keep.push_back(ld_q[i]);
        else m_flushed++;
      end
      ld_q = keep;
    end
    if (rd && !wr && !mis && !fl) begin
      ld_q.push_back('{e + LAT - 1, rob, mem_m[idx]});
      m_loads++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b0);
  endtask

  task automatic load(input logic [31:0] addr, input rob_addr_t rob);
    drive(1'b0, 1'b1, addr, 32'h0, rob, 1'b0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b0, addr, data, '0, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.ld_valid_out), 64'(0));
    chk({tag, "_rob"}, 64'(bus.ld_rob_addr_out), 64'(0));
    chk({tag, "_data"}, 64'(bus.ld_data_out), 64'(0));
    chk({tag, "_err"}, 64'(bus.req_err_out), 64'(0));
  endtask

`ifdef QU_DMEM_STATS_EN
  task automatic chk_stats(input string tag);
    chk({tag, "_loads"}, 64'(stat_loads), 64'(m_loads));
    chk({tag, "_stores"}, 64'(stat_stores), 64'(m_stores));
    chk({tag, "_errs"}, 64'(stat_errs), 64'(m_errs));
    chk({tag, "_flushed"}, 64'(stat_flushed), 64'(m_flushed));
  endtask
`endif

  initial begin
    bus.dmem_wr_en_in    = 1'b0;
    bus.dmem_rd_en_in    = 1'b0;
    bus.dmem_addr_in     = '0;
    bus.dmem_data_in     = '0;
    bus.dmem_rob_addr_in = '0;
    bus.flush_in         = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst    = 1'b1;
    mon_en = 1'b1;

    // Store then load
    store(32'h40, 32'hDEAD_BEEF);
    load(32'h40, 5'd3);
    idle(1);

    // Back-to-back loads
    store(32'h0, 32'hA000_0000);
    store(32'h4, 32'hA000_0004);
    store(32'h8, 32'hA000_0008);
    load(32'h0, 5'd1);
    load(32'h4, 5'd2);
    load(32'h8, 5'd3);
    idle(1);

    // Misaligned load and store; index 0x10 must keep its data
    load(32'h42, 5'd5);
    store(32'h41, 32'h5555_5555);
    load(32'h40, 5'd6);
    idle(1);

    // Flush together with a third load, then a normal load
    load(32'h0, 5'd7);
    load(32'h4, 5'd8);
    drive(1'b0, 1'b1, 32'h8, 32'h0, 5'd9, 1'b1);
    load(32'h40, 5'd10);
    idle(1);

    // Address wrap and read/write conflict
    store(32'(4 * DEPTH), 32'h11);
    load(32'h0, 5'd11);
    drive(1'b1, 1'b1, 32'h8, 32'h22, 5'd12, 1'b0);
    load(32'h8, 5'd13);
    idle(LAT + 1);
`ifdef QU_DMEM_STATS_EN
    chk_stats("stats_run");
`endif

    // Asynchronous reset with a load in flight
    load(32'h40, 5'd14);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    ld_q.delete();
    err_q.delete();
    last_data = '0;
    last_rob  = '0;
    m_loads   = 0;
    m_stores  = 0;
    m_errs    = 0;
    m_flushed = 0;
`ifdef QU_DMEM_STATS_EN
    chk_stats("stats_rst");
`endif
    @(negedge clk);
    bus.dmem_rd_en_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(LAT + 2);

    // RAM survives reset
    load(32'h40, 5'd15);
    idle(LAT + 2);
`ifdef QU_DMEM_STATS_EN
    chk_stats("stats_end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
